// File: rtl/ni_packetizer.sv
`timescale 1ns/1ps
// Purpose: local-port packet injector; turns a request (dest X/Y, 1..4 words) into HDR/BODY/TAIL 8-bit flits.
// Latency: header registered one cycle after request acceptance; each payload word appears as a flit one cycle after its handshake.
// Backpressure: credit counter (initial CREDITS) gates every flit; pay_ready drops and HEAD holds while no credit remains.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready, req_dest_x/y, req_len   packet request handshake (len 1..4)
//   pay_valid/pay_ready, pay_data     payload word handshake (6-bit words)
//   flit_out, flit_valid              registered flit stream to the router local input port
//   credit_in                         one-cycle pulse per freed router buffer slot
//   err                               one-cycle pulse when a request is rejected
//   busy                              state is not IDLE
module ni_packetizer #(
   parameter logic [1:0] X_ADDR  = 2'd1,
   parameter logic [1:0] Y_ADDR  = 2'd1,
   parameter int         CREDITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_dest_x,
   input  logic [1:0] req_dest_y,
   input  logic [2:0] req_len,
   input  logic       pay_valid,
   output logic       pay_ready,
   input  logic [5:0] pay_data,
   output logic [7:0] flit_out,
   output logic       flit_valid,
   input  logic       credit_in,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, HEAD, PAY} state_t;

   localparam logic [1:0] FLIT_HDR  = 2'b10;
   localparam logic [1:0] FLIT_BODY = 2'b00;
   localparam logic [1:0] FLIT_TAIL = 2'b01;
   localparam logic [2:0] CRED_MAX  = 3'(CREDITS);

   state_t     state;
   logic [2:0] cred;
   logic [1:0] dest_x;
   logic [1:0] dest_y;
   logic [1:0] hdr_len;   // req_len-1 as carried in the header
   logic [2:0] rem;       // payload words still to send

   logic has_cred;
   logic req_fire;
   logic pay_fire;
   logic hdr_send;
   logic send;
   logic bad_req;

   assign has_cred  = (cred != 3'd0);
   assign req_ready = (state == IDLE);
   assign pay_ready = (state == PAY) && has_cred;
   assign busy      = (state != IDLE);
   assign req_fire  = req_valid && req_ready;
   assign pay_fire  = pay_valid && pay_ready;
   assign hdr_send  = (state == HEAD) && has_cred;
   assign send      = hdr_send || pay_fire;

   // A packet addressed to this node would never leave the local port, so it is refused.
   assign bad_req = (req_len == 3'd0) || (req_len > 3'd4) ||
                    ((req_dest_x == X_ADDR) && (req_dest_y == Y_ADDR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cred       <= CRED_MAX;
         dest_x     <= 2'd0;
         dest_y     <= 2'd0;
         hdr_len    <= 2'd0;
         rem        <= 3'd0;
         flit_out   <= 8'h00;
         flit_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         flit_valid <= send;
         err        <= req_fire && bad_req;

         // Simultaneous send and returned credit cancel; a credit beyond the
         // buffer depth cannot be real and is dropped.
         if (send && !credit_in)
            cred <= cred - 3'd1;
         else if (!send && credit_in && (cred != CRED_MAX))
            cred <= cred + 3'd1;

         case (state)
            IDLE: begin
               if (req_fire) begin
                  dest_x  <= req_dest_x;
                  dest_y  <= req_dest_y;
                  hdr_len <= req_len[1:0] - 2'd1;  // len 4 wraps to 2'b11
                  rem     <= req_len;
                  if (!bad_req)
                     state <= HEAD;
               end
            end
            HEAD: begin
               if (has_cred) begin
                  flit_out <= {FLIT_HDR, hdr_len, dest_y, dest_x};
                  state    <= PAY;
               end
            end
            PAY: begin
               if (pay_fire) begin
                  rem <= rem - 3'd1;
                  if (rem == 3'd1) begin
                     flit_out <= {FLIT_TAIL, pay_data};
                     state    <= IDLE;
                  end else begin
                     flit_out <= {FLIT_BODY, pay_data};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_packetizer.sv
`timescale 1ns/1ps
// Directed bench for ni_packetizer: expected flits are queued as stimulus is driven
// and popped whenever the DUT presents a valid flit.
module tb_ni_packetizer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_dest_x;
   logic [1:0] req_dest_y;
   logic [2:0] req_len;
   logic       pay_valid;
   logic       pay_ready;
   logic [5:0] pay_data;
   logic [7:0] flit_out;
   logic       flit_valid;
   logic       credit_in;
   logic       err;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   ni_packetizer #(.X_ADDR(2'd1), .Y_ADDR(2'd1), .CREDITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_dest_x (req_dest_x),
      .req_dest_y (req_dest_y),
      .req_len    (req_len),
      .pay_valid  (pay_valid),
      .pay_ready  (pay_ready),
      .pay_data   (pay_data),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .credit_in  (credit_in),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Advance one clock, then score any flit the DUT presents.
   task automatic step();
      @(posedge clk);
      #1;
      if (flit_valid) begin
         if (exp_q.size() == 0)
            check1("spurious_flit", flit_valid, 1'b0);
         else
            check8("flit", flit_out, exp_q.pop_front());
      end
   endtask

   task automatic req(input logic [1:0] x, input logic [1:0] y, input logic [2:0] len);
      req_valid  = 1'b1;
      req_dest_x = x;
      req_dest_y = y;
      req_len    = len;
      check1("req_ready", req_ready, 1'b1);
      step();
      req_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_dest_x = 2'd0;
      req_dest_y = 2'd0;
      req_len    = 3'd0;
      pay_valid  = 1'b0;
      pay_data   = 6'd0;
      credit_in  = 1'b0;

      // ---- reset values
      step();
      step();
      check1("rst_req_ready",  req_ready,  1'b1);
      check1("rst_pay_ready",  pay_ready,  1'b0);
      check1("rst_flit_valid", flit_valid, 1'b0);
      check1("rst_busy",       busy,       1'b0);
      check1("rst_err",        err,        1'b0);
      check8("rst_flit_out",   flit_out,   8'h00);
      rst = 1'b0;
      step();

      // ---- len=4 to (0,0), no credit_in: exactly 4 flits then stall
      exp_q.push_back(8'hB0);
      req(2'd0, 2'd0, 3'd4);
      check1("a_busy_head", busy, 1'b1);
      check1("a_no_err", err, 1'b0);
      check1("a_hdr_not_yet", flit_valid, 1'b0);
      check1("a_pay_rdy_head", pay_ready, 1'b0);
      pay_valid = 1'b1;
      pay_data  = 6'h11;
      exp_q.push_back(8'h11);
      step();                                   // header
      check1("a_hdr_vld", flit_valid, 1'b1);
      check1("a_pay_rdy", pay_ready, 1'b1);
      step();                                   // body 11
      pay_data = 6'h22;
      exp_q.push_back(8'h22);
      step();                                   // body 22
      pay_data = 6'h33;
      exp_q.push_back(8'h33);
      step();                                   // body 33, credits exhausted
      check1("a_4th_vld", flit_valid, 1'b1);
      check1("a_stall_rdy", pay_ready, 1'b0);
      pay_data = 6'h3C;
      repeat (3) step();
      check1("a_stall_rdy2", pay_ready, 1'b0);
      check1("a_stall_noflit", flit_valid, 1'b0);
      check1("a_stall_busy", busy, 1'b1);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check1("a_rdy_after_cred", pay_ready, 1'b1);
      check1("a_no_flit_yet", flit_valid, 1'b0);
      exp_q.push_back(8'h7C);
      step();                                   // tail one cycle after handshake
      check1("a_tail_vld", flit_valid, 1'b1);
      check1("a_idle", busy, 1'b0);
      pay_valid = 1'b0;
      credit_in = 1'b1;
      repeat (4) step();                        // router returns the 4 slots
      credit_in = 1'b0;

      // ---- len=2 to (3,2): 9B, 15, 6A back-to-back
      exp_q.push_back(8'h9B);
      req(2'd3, 2'd2, 3'd2);
      check1("b_hdr_not_yet", flit_valid, 1'b0);
      check1("b_no_err", err, 1'b0);
      pay_valid = 1'b1;
      pay_data  = 6'h15;
      exp_q.push_back(8'h15);
      step();
      check1("b_hdr_vld", flit_valid, 1'b1);
      step();
      check1("b_body_vld", flit_valid, 1'b1);
      pay_data = 6'h2A;
      exp_q.push_back(8'h6A);
      step();
      check1("b_tail_vld", flit_valid, 1'b1);
      check1("b_busy_drop", busy, 1'b0);
      pay_valid = 1'b0;

      // ---- rejects (credits now 1, must stay 1)
      req(2'd1, 2'd1, 3'd2);
      check1("r_local_err", err, 1'b1);
      check1("r_local_noflit", flit_valid, 1'b0);
      check1("r_local_busy", busy, 1'b0);
      step();
      check1("r_err_pulse_end", err, 1'b0);
      req(2'd2, 2'd2, 3'd0);
      check1("r_len0_err", err, 1'b1);
      req(2'd2, 2'd2, 3'd5);
      check1("r_len5_err", err, 1'b1);
      check1("r_len5_busy", busy, 1'b0);
      step();
      check1("r_err_clear", err, 1'b0);
      check1("r_noflit", flit_valid, 1'b0);

      // ---- restore to 4, then a credit at full count must saturate
      credit_in = 1'b1;
      repeat (3) step();
      step();                                   // saturating credit
      credit_in = 1'b0;
      exp_q.push_back(8'hBE);
      req(2'd2, 2'd3, 3'd4);
      pay_valid = 1'b1;
      pay_data  = 6'h05;
      exp_q.push_back(8'h05);
      step();
      step();
      pay_data = 6'h0A;
      exp_q.push_back(8'h0A);
      step();
      pay_data = 6'h14;
      exp_q.push_back(8'h14);
      step();
      check1("c_4th_vld", flit_valid, 1'b1);
      pay_data = 6'h28;
      check1("c_fifth_stall_rdy", pay_ready, 1'b0);
      step();
      step();
      check1("c_fifth_stall", flit_valid, 1'b0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      exp_q.push_back(8'h68);
      step();
      check1("c_tail_vld", flit_valid, 1'b1);
      pay_valid = 1'b0;

      // ---- credit_in coincident with a send at count 2 keeps it at 2
      credit_in = 1'b1;
      repeat (2) step();
      credit_in = 1'b0;
      exp_q.push_back(8'h94);
      req(2'd0, 2'd1, 3'd2);
      credit_in = 1'b1;
      pay_valid = 1'b1;
      pay_data  = 6'h07;
      exp_q.push_back(8'h07);
      step();                                   // header + credit: stays 2
      credit_in = 1'b0;
      check1("d_hdr_vld", flit_valid, 1'b1);
      step();                                   // body: 1
      check1("d_body_vld", flit_valid, 1'b1);
      pay_data = 6'h30;
      exp_q.push_back(8'h70);
      step();                                   // tail: 0
      check1("d_tail_vld", flit_valid, 1'b1);
      pay_valid = 1'b0;
      req(2'd0, 2'd2, 3'd1);
      step();
      check1("d_hdr_stall", flit_valid, 1'b0);
      check1("d_hdr_stall_busy", busy, 1'b1);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check1("d_hdr_wait", flit_valid, 1'b0);
      exp_q.push_back(8'h88);
      step();
      check1("d_hdr_vld2", flit_valid, 1'b1);
      pay_valid = 1'b1;
      pay_data  = 6'h01;
      check1("d_pay_stall", pay_ready, 1'b0);
      step();
      check1("d_tail_stall", flit_valid, 1'b0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      exp_q.push_back(8'h41);
      step();
      check1("d_tail_vld2", flit_valid, 1'b1);
      pay_valid = 1'b0;

      // ---- reset mid-packet
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      exp_q.push_back(8'hAF);
      req(2'd3, 2'd3, 3'd3);
      step();
      check1("e_hdr_vld", flit_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check1("e_async_flit_valid", flit_valid, 1'b0);
      check8("e_async_flit_out", flit_out, 8'h00);
      check1("e_async_busy", busy, 1'b0);
      check1("e_async_req_ready", req_ready, 1'b1);
      step();
      rst = 1'b0;
      exp_q.push_back(8'h86);
      req(2'd2, 2'd1, 3'd1);
      check1("e_hdr_not_yet", flit_valid, 1'b0);
      pay_valid = 1'b1;
      pay_data  = 6'h2D;
      exp_q.push_back(8'h6D);
      step();
      check1("e_hdr2_vld", flit_valid, 1'b1);
      step();
      check1("e_tail_vld", flit_valid, 1'b1);
      check1("e_idle", busy, 1'b0);
      pay_valid = 1'b0;
      step();
      step();
      check8("queue_empty", 8'(exp_q.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Local-port packet injector for a mesh node of the 4x4 YaNoC mesh. It accepts a packet request (destination X/Y plus 1-4 six-bit payload words) and serialises it into 8-bit flits on the router's local input port: one header flit, then body flits, then a tail flit. It is the transmitter whose header format the per-port routing logic decodes. Credit-based flow control stops it from overrunning the router's local input buffer.

## Interface
- `X_ADDR`, default 1: local node X coordinate (2 bits).
- `Y_ADDR`, default 1: local node Y coordinate (2 bits).
- `CREDITS`, default 4: depth of the router local input buffer, and the initial credit count (1..7).
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `req_valid`  in  1: packet request valid.
- `req_ready`  out  1: request accepted when high with `req_valid`.
- `req_dest_x`  in  2: destination X.
- `req_dest_y`  in  2: destination Y.
- `req_len`  in  3: number of payload words; legal values are 1..4.
- `pay_valid`  in  1: payload word valid.
- `pay_ready`  out  1: payload word accepted when high with `pay_valid`.
- `pay_data`  in  6: payload word.
- `flit_out`  out  8: flit to the router local port.
- `flit_valid`  out  1: `flit_out` is valid this cycle (one flit per high cycle).
- `credit_in`  in  1: one buffer slot freed by the router (1-cycle pulse per slot).
- `err`  out  1: 1-cycle pulse when a request is rejected.
- `busy`  out  1: high when the state is not IDLE.

## Operation
- Flit format:
  - Bits [7:6] are the type: HDR=2'b10, BODY=2'b00, TAIL=2'b01.
  - Header: [5:4] = req_len-1, [3:2] = dest_y, [1:0] = dest_x.
  - Body and tail: [5:0] = payload word.
- The last payload word is always carried in the TAIL flit. When len=1 the packet is header then tail.
- State machine has three states: IDLE, HEAD, PAY.
  - IDLE: `req_ready`=1. On acceptance, latch dest and len.
    - If len is 0 or greater than 4, or if dest equals (X_ADDR, Y_ADDR): the request is rejected, `err` pulses, and the state stays IDLE.
    - Otherwise go to HEAD.
  - HEAD: if credit count > 0, register the header flit and go to PAY. Otherwise hold.
  - PAY: `pay_ready` = (credit count > 0).
    - On each pay handshake, register a BODY flit, or a TAIL flit when it is the last word, and decrement the remaining-word count.
    - The handshake that produces the tail returns the state to IDLE.
- Credit counter (3 bits):
  - −1 on each registered flit, +1 on `credit_in`. Both in the same cycle leaves it unchanged.
  - `credit_in` while the count is at CREDITS saturates (no change).
  - No flit is ever emitted while the count is 0.
- `req_ready` and `pay_ready` are combinational from state and credit count. They must not depend on `req_valid` or `pay_valid`.
- `pay_valid` is ignored outside PAY. `req_valid` is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, credit count=CREDITS.
  - `flit_out`=8'h00, `flit_valid`=0, `err`=0, `busy`=0.
  - `req_ready`=1, `pay_ready`=0.
- `flit_out`, `flit_valid` and `err` are registered.
- Request accepted at edge E0: HEAD during cycle E0..E1, header valid E1..E2 when credit is available. Each cycle without credit adds one cycle.
- Payload accepted at edge En: the flit is valid in the following cycle, so latency is 1. With continuous `pay_valid` and credit, flits are back-to-back.
- A new request can be accepted in the cycle after the tail is registered. No idle gap is required on `flit_valid`.
- Rejected request accepted at E0: `err`=1 for exactly the cycle E0..E1. `flit_valid` stays 0 and credits are unchanged.
- Reset asserted mid-packet: outputs go to their reset values immediately, asynchronously. The partial packet is abandoned and credits are restored to CREDITS; the router is reset together with this block.

## Test plan
- **Reset:** after `rst`, `req_ready`=1, `flit_valid`=0, `busy`=0 and the credit count is 4, checked via 4 back-to-back flits without `credit_in`.
- **len=2 packet:** request dest (3,2), len=2, payload 6'h15 then 6'h2A, credits available → flits 8'h9B, 8'h15, 8'h6A on consecutive valid cycles. The header appears 2 cycles after acceptance; `busy` drops after the tail.
- **Credit stall:** request len=4 to (0,0) with `credit_in` held 0 → header plus 3 bodies (4 flits), then `pay_ready`=0 and no flit. A single `credit_in` pulse → tail 8'h40|data one cycle after the pay handshake.
- **Rejects:** request dest (1,1) with len=2 → `err` pulse, no flit, `busy`=0. Request len=0 and request len=5 → `err` each time.
- **Credit arithmetic:** `credit_in` in the same cycle as a flit send at count 2 → count stays 2. `credit_in` at count 4 → stays 4, so the fifth consecutive flit stalls.
- **Reset mid-packet:** assert `rst` after the header of a len=3 packet → `flit_valid`=0 immediately. After release, a new len=1 request to (2,1) → 8'h86, then 8'h40|data.
